// File: rtl/ssemi_adc_decimator_cfg_sequencer.sv
// Purpose: boot-time sequencer; walks a {addr,data} table into the decimator CSR port, writes enable, polls ready.
// Latency: 3 cycles/word (4 with SSEMI_ADC_DECIMATOR_CFG_READBACK_EN readback), +ENABLE +POLL(s) +DONE.
// Backpressure: each CSR write holds valid/addr/data until i_csr_wr_ready; decimator error aborts any step.
module ssemi_adc_decimator_cfg_sequencer #(
    parameter int          NUM_WORDS   = 64,
    parameter int          TABLE_AW    = 8,
    parameter logic [7:0]  CTRL_ADDR   = 8'h00,
    parameter logic [31:0] ENABLE_WORD = 32'h0000_0001,
    parameter logic [7:0]  STATUS_ADDR = 8'h04,
    parameter int          READY_BIT   = 0,
    parameter int          POLL_LIMIT  = 1024
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_start,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_error,
    output logic [1:0]          o_err_code,
    output logic                o_tbl_rd_en,
    output logic [TABLE_AW-1:0] o_tbl_addr,
    input  logic [39:0]         i_tbl_data,
    output logic                o_csr_wr_valid,
    output logic [7:0]          o_csr_addr,
    output logic [31:0]         o_csr_wr_data,
    input  logic                i_csr_wr_ready,
    output logic                o_csr_rd_ready,
    input  logic [31:0]         i_csr_rd_data,
    input  logic                i_decim_error
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_WRITE,
`ifdef SSEMI_ADC_DECIMATOR_CFG_READBACK_EN
        S_VERIFY,
`endif
        S_ENABLE,
        S_POLL,
        S_DONE,
        S_FAIL
    } state_t;

    localparam logic [TABLE_AW-1:0] LAST_IDX     = TABLE_AW'(NUM_WORDS - 1);
    localparam logic [16:0]         POLL_LIMIT_W = 17'(POLL_LIMIT);

    localparam logic [1:0] ERR_READBACK = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
    localparam logic [1:0] ERR_DECIM    = 2'd3;

    state_t                state_q;
    logic                  busy_q, done_q, error_q;
    logic [1:0]            err_code_q;
    logic                  tbl_rd_en_q;
    logic [TABLE_AW-1:0]   tbl_addr_q;
    logic                  csr_wr_valid_q, csr_rd_ready_q;
    logic [7:0]            csr_addr_q;
    logic [31:0]           csr_wr_data_q;
    logic [16:0]           poll_cnt_q;

    logic [16:0]           poll_cnt_d;
    logic [TABLE_AW-1:0]   idx_d;
    logic                  last_word;
    logic                  abort;

    // The table index doubles as the table address register.
    assign poll_cnt_d = poll_cnt_q + 17'd1;
    assign idx_d      = tbl_addr_q + 1'b1;
    assign last_word  = (tbl_addr_q == LAST_IDX);
    // A decimator error only matters while a sequence is actively running.
    assign abort      = i_decim_error && (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_FAIL);

    // Only READY_BIT feeds the poll decision in the default build; fold the rest away explicitly.
    logic unused_rd_data;
    assign unused_rd_data = ^i_csr_rd_data;

    // Sequencer FSM; every output is a register loaded on entry to the state that drives it.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q        <= S_IDLE;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
            err_code_q     <= 2'd0;
            tbl_rd_en_q    <= 1'b0;
            tbl_addr_q     <= '0;
            csr_wr_valid_q <= 1'b0;
            csr_rd_ready_q <= 1'b0;
            csr_addr_q     <= 8'h00;
            csr_wr_data_q  <= 32'h0;
            poll_cnt_q     <= 17'd0;
        end else begin
            done_q      <= 1'b0;
            tbl_rd_en_q <= 1'b0;
            if (abort) begin
                // Error wins even over a write completing in this same cycle.
                state_q        <= S_FAIL;
                error_q        <= 1'b1;
                err_code_q     <= ERR_DECIM;
                csr_wr_valid_q <= 1'b0;
                csr_rd_ready_q <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (i_start) begin
                            state_q     <= S_FETCH;
                            busy_q      <= 1'b1;
                            tbl_addr_q  <= '0;
                            tbl_rd_en_q <= 1'b1;
                            poll_cnt_q  <= 17'd0;
                            error_q     <= 1'b0;
                            err_code_q  <= 2'd0;
                        end
                    end
                    S_FETCH: begin
                        state_q <= S_LATCH;
                    end
                    S_LATCH: begin
                        csr_addr_q     <= i_tbl_data[39:32];
                        csr_wr_data_q  <= i_tbl_data[31:0];
                        csr_wr_valid_q <= 1'b1;
                        state_q        <= S_WRITE;
                    end
                    S_WRITE: begin
                        if (i_csr_wr_ready) begin
                            csr_wr_valid_q <= 1'b0;
`ifdef SSEMI_ADC_DECIMATOR_CFG_READBACK_EN
                            csr_rd_ready_q <= 1'b1;
                            state_q        <= S_VERIFY;
`else
                            if (last_word) begin
                                csr_wr_valid_q <= 1'b1;
                                csr_addr_q     <= CTRL_ADDR;
                                csr_wr_data_q  <= ENABLE_WORD;
                                state_q        <= S_ENABLE;
                            end else begin
                                tbl_addr_q  <= idx_d;
                                tbl_rd_en_q <= 1'b1;
                                state_q     <= S_FETCH;
                            end
`endif
                        end
                    end
`ifdef SSEMI_ADC_DECIMATOR_CFG_READBACK_EN
                    S_VERIFY: begin
                        csr_rd_ready_q <= 1'b0;
                        if (i_csr_rd_data != csr_wr_data_q) begin
                            error_q    <= 1'b1;
                            err_code_q <= ERR_READBACK;
                            state_q    <= S_FAIL;
                        end else if (last_word) begin
                            csr_wr_valid_q <= 1'b1;
                            csr_addr_q     <= CTRL_ADDR;
                            csr_wr_data_q  <= ENABLE_WORD;
                            state_q        <= S_ENABLE;
                        end else begin
                            tbl_addr_q  <= idx_d;
                            tbl_rd_en_q <= 1'b1;
                            state_q     <= S_FETCH;
                        end
                    end
`endif
                    S_ENABLE: begin
                        if (i_csr_wr_ready) begin
                            csr_wr_valid_q <= 1'b0;
                            csr_addr_q     <= STATUS_ADDR;
                            csr_rd_ready_q <= 1'b1;
                            state_q        <= S_POLL;
                        end
                    end
                    S_POLL: begin
                        poll_cnt_q <= poll_cnt_d;
                        if (i_csr_rd_data[READY_BIT]) begin
                            csr_rd_ready_q <= 1'b0;
                            done_q         <= 1'b1;
                            state_q        <= S_DONE;
                        end else if (poll_cnt_d == POLL_LIMIT_W) begin
                            csr_rd_ready_q <= 1'b0;
                            error_q        <= 1'b1;
                            err_code_q     <= ERR_TIMEOUT;
                            state_q        <= S_FAIL;
                        end
                    end
                    S_DONE: begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                    S_FAIL: begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign o_busy         = busy_q;
    assign o_done         = done_q;
    assign o_error        = error_q;
    assign o_err_code     = err_code_q;
    assign o_tbl_rd_en    = tbl_rd_en_q;
    assign o_tbl_addr     = tbl_addr_q;
    assign o_csr_wr_valid = csr_wr_valid_q;
    assign o_csr_addr     = csr_addr_q;
    assign o_csr_wr_data  = csr_wr_data_q;
    assign o_csr_rd_ready = csr_rd_ready_q;

endmodule

// File: tb/tb_ssemi_adc_decimator_cfg_sequencer.sv
// Scoreboard bench for the ADC decimator configuration sequencer (NUM_WORDS=4, POLL_LIMIT=16).
// Expected CSR writes/reads, done and error events are queued by the stimulus; a negedge monitor pops and compares.
// Cycle numbers count from the start cycle: cycle 1 is the first cycle after i_start is accepted.
module tb_ssemi_adc_decimator_cfg_sequencer;

    localparam int          NW     = 4;
    localparam logic [7:0]  CTRL   = 8'h00;
    localparam logic [31:0] ENWORD = 32'h0000_0001;
    localparam logic [7:0]  STATUS = 8'h04;
`ifdef SSEMI_ADC_DECIMATOR_CFG_READBACK_EN
    localparam int WC = 4;
`else
    localparam int WC = 3;
`endif

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_start = 1'b0;
    logic        o_busy, o_done, o_error;
    logic [1:0]  o_err_code;
    logic        o_tbl_rd_en;
    logic [7:0]  o_tbl_addr;
    logic [39:0] i_tbl_data = 40'h0;
    logic        o_csr_wr_valid;
    logic [7:0]  o_csr_addr;
    logic [31:0] o_csr_wr_data;
    logic        i_csr_wr_ready = 1'b1;
    logic        o_csr_rd_ready;
    logic [31:0] i_csr_rd_data;
    logic        i_decim_error = 1'b0;

    logic [31:0] status_val = 32'h1;
    logic        corrupt = 1'b0;
    logic [39:0] tbl [0:255];

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    ssemi_adc_decimator_cfg_sequencer #(
        .NUM_WORDS(NW), .TABLE_AW(8), .CTRL_ADDR(CTRL), .ENABLE_WORD(ENWORD),
        .STATUS_ADDR(STATUS), .READY_BIT(0), .POLL_LIMIT(16)
    ) dut (
        .i_clk(clk), .i_rst(i_rst), .i_start(i_start),
        .o_busy(o_busy), .o_done(o_done), .o_error(o_error), .o_err_code(o_err_code),
        .o_tbl_rd_en(o_tbl_rd_en), .o_tbl_addr(o_tbl_addr), .i_tbl_data(i_tbl_data),
        .o_csr_wr_valid(o_csr_wr_valid), .o_csr_addr(o_csr_addr), .o_csr_wr_data(o_csr_wr_data),
        .i_csr_wr_ready(i_csr_wr_ready), .o_csr_rd_ready(o_csr_rd_ready),
        .i_csr_rd_data(i_csr_rd_data), .i_decim_error(i_decim_error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous table memory: data valid the cycle after the read strobe.
    always @(posedge clk) if (o_tbl_rd_en) i_tbl_data <= tbl[o_tbl_addr];

    // CSR slave: status register at STATUS, table registers read back their table value.
    always_comb begin
        i_csr_rd_data = 32'h0;
        if (o_csr_addr == STATUS) i_csr_rd_data = status_val;
        else
            for (int i = 0; i < NW; i++)
                if (tbl[i][39:32] == o_csr_addr)
                    i_csr_rd_data = tbl[i][31:0] ^ ((corrupt && i == 3) ? 32'h1 : 32'h0);
    end

    // kind: 0 write, 1 read, 2 done, 3 error (data = code). at < 0 means any cycle.
    typedef struct {
        int          kind;
        logic [7:0]  addr;
        logic [31:0] data;
        int          at;
    } exp_t;
    exp_t q[$];
    int   s0 = 0;

    task automatic push(input int kind, input logic [7:0] a, input logic [31:0] d, input int at);
        exp_t e;
        e.kind = kind; e.addr = a; e.data = d; e.at = at;
        q.push_back(e);
    endtask

    task automatic push_words(input int n);
        for (int i = 0; i < n; i++) begin
            push(0, tbl[i][39:32], tbl[i][31:0], -1);
`ifdef SSEMI_ADC_DECIMATOR_CFG_READBACK_EN
            push(1, tbl[i][39:32], 32'h0, -1);
`endif
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc - s0);
        end
    endtask

    task automatic check_evt(input int kind, input logic [7:0] a, input logic [31:0] d);
        exp_t e;
        tests++;
        if (q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_event: got kind %0d addr %h data %h at cycle %0d, expected nothing", kind, a, d, cyc - s0);
        end else begin
            e = q.pop_front();
            if (e.kind != kind || e.addr !== a || e.data !== d || (e.at >= 0 && e.at != cyc - s0)) begin
                fails++;
                $display("FAIL event: got kind %0d addr %h data %h cycle %0d, expected kind %0d addr %h data %h cycle %0d",
                         kind, a, d, cyc - s0, e.kind, e.addr, e.data, e.at);
            end
        end
    endtask

    // Monitor: sampled mid-cycle, away from the active edge.
    logic        p_stall = 1'b0;
    logic        p_err = 1'b0;
    logic [7:0]  p_addr = 8'h0;
    logic [31:0] p_data = 32'h0;
    always @(negedge clk) begin
        if (i_rst) begin
            p_stall = 1'b0;
            p_err   = 1'b0;
        end else begin
            if (o_csr_wr_valid || o_csr_rd_ready)
                check("strobe_exclusive", 32'(o_csr_wr_valid && o_csr_rd_ready), 32'h0);
            if (p_stall) begin
                check("stall_valid_held", 32'(o_csr_wr_valid), 32'h1);
                check("stall_addr_held", 32'(o_csr_addr), 32'(p_addr));
                check("stall_data_held", o_csr_wr_data, p_data);
            end
            if (o_csr_wr_valid && i_csr_wr_ready && !i_decim_error) check_evt(0, o_csr_addr, o_csr_wr_data);
            if (o_csr_rd_ready) check_evt(1, o_csr_addr, 32'h0);
            if (o_done) check_evt(2, 8'h00, 32'h0);
            if (o_error && !p_err) check_evt(3, 8'h00, 32'(o_err_code));
            p_stall = o_csr_wr_valid && !i_csr_wr_ready && !i_decim_error;
            p_addr  = o_csr_addr;
            p_data  = o_csr_wr_data;
            p_err   = o_error;
        end
    end

    // Pulse start; on return we are #1 into cycle 1 and s0 is the start cycle number.
    task automatic do_start();
        @(posedge clk); #1 i_start = 1'b1;
        @(posedge clk); #1 i_start = 1'b0;
        s0 = cyc - 1;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 32'(o_busy), 32'h0);
        check({tag, "_done"}, 32'(o_done), 32'h0);
        check({tag, "_error"}, 32'(o_error), 32'h0);
        check({tag, "_err_code"}, 32'(o_err_code), 32'h0);
        check({tag, "_tbl_rd_en"}, 32'(o_tbl_rd_en), 32'h0);
        check({tag, "_tbl_addr"}, 32'(o_tbl_addr), 32'h0);
        check({tag, "_wr_valid"}, 32'(o_csr_wr_valid), 32'h0);
        check({tag, "_csr_addr"}, 32'(o_csr_addr), 32'h0);
        check({tag, "_wr_data"}, o_csr_wr_data, 32'h0);
        check({tag, "_rd_ready"}, 32'(o_csr_rd_ready), 32'h0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) tbl[i] = 40'h0;
        tbl[0] = {8'h10, 32'hA5A5_0001};
        tbl[1] = {8'h14, 32'h1234_5678};
        tbl[2] = {8'h18, 32'hDEAD_BEEF};
        tbl[3] = {8'h1C, 32'h0000_00FF};

        // Reset state
        wait_cycles(3);
        check_all_zero("reset");
        i_rst = 1'b0;
        wait_cycles(2);

        // T1: nominal sequence, done at cycle 3*4+3; a start while busy is ignored
        do_start();
        push_words(NW);
        push(0, CTRL, ENWORD, -1);
        push(1, STATUS, 32'h0, -1);
        push(2, 8'h00, 32'h0, 4 * WC + 3);
        check("t1_busy_after_start", 32'(o_busy), 32'h1);
        wait_cycles(4);
        i_start = 1'b1;
        wait_cycles(1);
        i_start = 1'b0;
        wait_cycles(40);
        check("t1_error", 32'(o_error), 32'h0);
        check("t1_busy_idle", 32'(o_busy), 32'h0);
        check("t1_drained", 32'(q.size()), 32'h0);

        // T2: ready low for the 5 WRITE cycles of word 1; done 5 cycles later
        do_start();
        push_words(NW);
        push(0, CTRL, ENWORD, -1);
        push(1, STATUS, 32'h0, -1);
        push(2, 8'h00, 32'h0, 4 * WC + 3 + 5);
        wait_cycles(WC + 1);
        i_csr_wr_ready = 1'b0;
        wait_cycles(6);
        i_csr_wr_ready = 1'b1;
        wait_cycles(40);
        check("t2_error", 32'(o_error), 32'h0);
        check("t2_drained", 32'(q.size()), 32'h0);

        // T3: status never ready -> 16 polls, then timeout (code 2)
        status_val = 32'h0;
        do_start();
        push_words(NW);
        push(0, CTRL, ENWORD, -1);
        for (int i = 0; i < 16; i++) push(1, STATUS, 32'h0, -1);
        push(3, 8'h00, 32'h2, 4 * WC + 18);
        wait_cycles(60);
        check("t3_error", 32'(o_error), 32'h1);
        check("t3_err_code", 32'(o_err_code), 32'h2);
        check("t3_busy", 32'(o_busy), 32'h0);
        check("t3_drained", 32'(q.size()), 32'h0);
        status_val = 32'h1;

        // T4: decimator error during word 1 write -> code 3, no further traffic; start clears old error
        do_start();
        check("t4_error_cleared", 32'(o_error), 32'h0);
        check("t4_code_cleared", 32'(o_err_code), 32'h0);
        push_words(1);
        push(3, 8'h00, 32'h3, WC + 4);
        wait_cycles(WC + 2);
        i_decim_error = 1'b1;
        wait_cycles(1);
        i_decim_error = 1'b0;
        wait_cycles(40);
        check("t4_err_code", 32'(o_err_code), 32'h3);
        check("t4_drained", 32'(q.size()), 32'h0);

`ifdef SSEMI_ADC_DECIMATOR_CFG_READBACK_EN
        // T5: readback of word 3 corrupted -> code 1, enable never written
        corrupt = 1'b1;
        do_start();
        push_words(NW);
        push(3, 8'h00, 32'h1, 4 * WC + 1);
        wait_cycles(40);
        check("t5_err_code", 32'(o_err_code), 32'h1);
        check("t5_drained", 32'(q.size()), 32'h0);
        corrupt = 1'b0;
`endif

        // T6: reset during a stalled word-0 write, then a full clean run
        i_csr_wr_ready = 1'b0;
        do_start();
        wait_cycles(2);
        check("t6_stalled_valid", 32'(o_csr_wr_valid), 32'h1);
        i_rst = 1'b1;
        wait_cycles(1);
        check_all_zero("t6_reset");
        i_rst = 1'b0;
        i_csr_wr_ready = 1'b1;
        wait_cycles(2);
        check("t6_drained_after_reset", 32'(q.size()), 32'h0);
        do_start();
        push_words(NW);
        push(0, CTRL, ENWORD, -1);
        push(1, STATUS, 32'h0, -1);
        push(2, 8'h00, 32'h0, 4 * WC + 3);
        wait_cycles(40);
        check("t6_error", 32'(o_error), 32'h0);
        check("t6_drained", 32'(q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ssemi_adc_decimator_cfg_sequencer.md
# ssemi_adc_decimator_cfg_sequencer

Boot-time configuration sequencer for the ADC decimator system top. On a start request it walks a configuration table of {CSR address, data} words and issues each as a write on the decimator's CSR write port. It then writes the enable word and polls the status register until the decimator reports ready. It reports done or a coded error, and sits between the SoC boot controller and the decimator's CSR interface.

## Interface
Parameters:
- NUM_WORDS, 64: configuration table entries (1..256), excluding the enable word.
- TABLE_AW, 8: table address width; must satisfy 2^TABLE_AW >= NUM_WORDS.
- CTRL_ADDR, 8'h00: CSR address that receives the enable word.
- ENABLE_WORD, 32'h0000_0001: data written to CTRL_ADDR after the table.
- STATUS_ADDR, 8'h04: CSR address polled for readiness.
- READY_BIT, 0: bit of the status word that means ready.
- POLL_LIMIT, 1024: maximum status reads before timeout (1..65535).

Ports (clock and reset first):
- i_clk  in  1  system clock
- i_rst  in  1  synchronous reset, active-high
- i_start  in  1  start pulse; sampled only in IDLE
- o_busy  out  1  sequence in progress
- o_done  out  1  one-cycle pulse on successful completion
- o_error  out  1  sticky failure flag; cleared by the next accepted i_start
- o_err_code  out  2  0 none, 1 readback mismatch, 2 poll timeout, 3 decimator error
- o_tbl_rd_en  out  1  table read strobe
- o_tbl_addr  out  TABLE_AW  table index
- i_tbl_data  in  40  table word {addr[39:32], data[31:0]}; valid exactly 1 cycle after o_tbl_rd_en
- o_csr_wr_valid  out  1  CSR write valid
- o_csr_addr  out  8  CSR address, shared by reads and writes
- o_csr_wr_data  out  32  CSR write data
- i_csr_wr_ready  in  1  CSR write ready
- o_csr_rd_ready  out  1  CSR read strobe; data is valid in the same cycle
- i_csr_rd_data  in  32  CSR read data
- i_decim_error  in  1  decimator error interrupt

## Operation
- States: IDLE, FETCH, LATCH, WRITE, VERIFY (macro only), ENABLE, POLL, DONE, FAIL.
- IDLE:
  - i_start=1 → FETCH.
  - Accepting a start clears the index, the poll counter, o_error and o_err_code.
- FETCH: o_tbl_rd_en=1, o_tbl_addr=idx → LATCH.
- LATCH: register i_tbl_data into the address and data registers → WRITE.
- WRITE:
  - o_csr_wr_valid=1, with o_csr_addr and o_csr_wr_data held stable until i_csr_wr_ready=1.
  - The transfer completes in the cycle where valid and ready are both high.
  - Next state: VERIFY if compiled in; otherwise FETCH with idx+1, or ENABLE when idx==NUM_WORDS-1.
- ENABLE: write handshake as in WRITE, using CTRL_ADDR/ENABLE_WORD → POLL.
- POLL:
  - Each cycle: o_csr_addr=STATUS_ADDR, o_csr_rd_ready=1, poll counter +1.
  - i_csr_rd_data[READY_BIT]=1 → DONE.
  - Counter reaching POLL_LIMIT without ready → FAIL with code 2.
- DONE: o_done=1 for one cycle → IDLE.
- FAIL: o_error=1 and o_err_code latched → IDLE. o_error and o_err_code stay held in IDLE.
- i_decim_error=1 in any state other than IDLE/DONE/FAIL → FAIL with code 3. This has priority over every other transition in that cycle, including a completing handshake.
- i_start while busy is ignored.
- o_csr_wr_valid and o_csr_rd_ready are never high in the same cycle.

## Timing
- Reset values:
  - Control outputs: o_busy, o_done, o_error, o_tbl_rd_en, o_csr_wr_valid, o_csr_rd_ready all 0.
  - Data outputs: o_err_code, o_tbl_addr, o_csr_addr, o_csr_wr_data all 0.
  - State: IDLE.
- Reset mid-sequence:
  - Returns to IDLE on the next edge and drops any pending write.
  - No done or error is reported.
- o_busy=1 from the cycle after start acceptance through the cycle before DONE/FAIL is exited. It is 0 in IDLE.
- Per-word cost: 3 cycles with ready tied high; 4 cycles with VERIFY.
- Total successful sequence with ready tied high, no macro, status ready on first read: 3·NUM_WORDS + 1 (ENABLE) + 1 (POLL) + 1 (DONE) cycles after the start cycle.
- All outputs are registered. No combinational path from any input to any output.

## Configuration
- SSEMI_ADC_DECIMATOR_CFG_READBACK_EN defined:
  - After each table write, VERIFY drives o_csr_rd_ready=1 with the same address for one cycle.
  - i_csr_rd_data != written data → FAIL with code 1.
  - The enable word is not verified.
- Macro undefined: the VERIFY state and compare logic are absent; WRITE goes directly to FETCH/ENABLE; code 1 never occurs.

## Test plan
- NUM_WORDS=4, ready tied high, status returns 32'h1 → four writes in table order, then 8'h00←32'h1; o_done pulses at cycle 15 after start; o_error=0.
- i_csr_wr_ready low for 5 cycles during word 2 → address and data held stable throughout; exactly one transfer; total latency +5.
- Status returns 32'h0 always, POLL_LIMIT=16 → exactly 16 status reads; o_error=1, o_err_code=2; i_start is then accepted and clears the error.
- i_decim_error pulsed during word 1 write → FAIL with code 3; no further CSR traffic.
- With the macro defined, readback of word 3 returns data^1 → o_err_code=1; the enable write is never issued.
- i_rst asserted mid-write → next cycle all outputs are 0 and the state is IDLE; a new start runs the full sequence from index 0.
